// File: rtl/gabor_conv_stream.sv
// ---------------------------------------------------------------------------
// gabor_conv_stream
//
// Streaming grouped-coefficient Gabor convolution. Each accepted beat carries
// one KSIZE x KSIZE window. Pixels are summed per coefficient group, each
// group sum is multiplied by its coefficient, and the products are
// accumulated. The result is rounded half-up to an integer and saturated to
// OUT_W bits. The pixel-to-group map and the coefficients are programmable and
// double-buffered. Writes go to a shadow bank. A commit copies shadow to
// active once the pipeline is empty.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      window beat valid
//   in_ready      window beat accepted this cycle
//   in_pixels     NPIX signed PIX_W pixels, row-major, pixel 0 in the LSBs
//   out_valid     response valid
//   out_ready     downstream accepts the response
//   out_data      signed OUT_W response
//   out_sat       out_data was clipped (qualified by out_valid)
//   cfg_we        shadow write strobe
//   cfg_sel       0 = map entry, 1 = coefficient
//   cfg_addr      pixel index (map) or group index (coefficient)
//   cfg_data      coefficient, or group index in the low GIDX_W bits
//   cfg_commit    request a shadow -> active swap
//   cfg_pending   commit requested but not yet applied
// ---------------------------------------------------------------------------
module gabor_conv_stream #(
    parameter int KSIZE      = 5,
    parameter int NGROUP     = 5,
    parameter int PIX_W      = 9,
    parameter int COEFF_W    = 17,
    parameter int COEFF_FRAC = 15,
    parameter int OUT_W      = 20
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [KSIZE*KSIZE*PIX_W-1:0]         in_pixels,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [OUT_W-1:0]                     out_data,
    output logic                                 out_sat,
    input  logic                                 cfg_we,
    input  logic                                 cfg_sel,
    input  logic [$clog2(KSIZE*KSIZE)-1:0]       cfg_addr,
    input  logic [COEFF_W-1:0]                   cfg_data,
    input  logic                                 cfg_commit,
    output logic                                 cfg_pending
);

    localparam int NPIX   = KSIZE * KSIZE;
    localparam int ADDR_W = $clog2(NPIX);
    localparam int GIDX_W = (NGROUP > 1) ? $clog2(NGROUP) : 1;
    localparam int SUM_W  = PIX_W + $clog2(NPIX);
    localparam int PROD_W = SUM_W + COEFF_W;
    localparam int ACC_W  = PROD_W + $clog2(NGROUP) + 1;

    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1 << (COEFF_FRAC - 1));
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(1 << (OUT_W - 1)));

    // Configuration banks
    logic [GIDX_W-1:0]         map_sh_q   [NPIX];
    logic [GIDX_W-1:0]         map_sh_d   [NPIX];
    logic [GIDX_W-1:0]         map_act_q  [NPIX];
    logic [GIDX_W-1:0]         map_act_d  [NPIX];
    logic signed [COEFF_W-1:0] coef_sh_q  [NGROUP];
    logic signed [COEFF_W-1:0] coef_sh_d  [NGROUP];
    logic signed [COEFF_W-1:0] coef_act_q [NGROUP];
    logic signed [COEFF_W-1:0] coef_act_d [NGROUP];
    logic                      cfg_pending_q, cfg_pending_d;

    // Pipeline: [0] captured window, [1] group sums, [2] products,
    // [3] accumulator, [4] rounded/saturated output register.
    logic [4:0]                valid_q, valid_d;
    logic signed [PIX_W-1:0]   pix_q     [NPIX];
    logic signed [PIX_W-1:0]   pix_d     [NPIX];
    logic signed [SUM_W-1:0]   sum_q     [NGROUP];
    logic signed [SUM_W-1:0]   sum_d     [NGROUP];
    logic signed [SUM_W-1:0]   sum_calc  [NGROUP];
    logic signed [PROD_W-1:0]  prod_q    [NGROUP];
    logic signed [PROD_W-1:0]  prod_d    [NGROUP];
    logic signed [PROD_W-1:0]  prod_calc [NGROUP];
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_calc;
    logic signed [ACC_W-1:0]   rnd, shifted;
    logic [OUT_W-1:0]          out_data_q, out_data_d, out_calc;
    logic                      out_sat_q, out_sat_d, sat_calc;

    logic adv;
    logic accept;
    logic pipe_empty;
    logic swap;

    assign adv         = !valid_q[4] || out_ready;
    assign in_ready    = adv && !cfg_pending_q;
    assign accept      = in_valid && in_ready;
    assign pipe_empty  = (valid_q == '0);
    assign swap        = (cfg_pending_q || cfg_commit) && pipe_empty;

    assign out_valid   = valid_q[4];
    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;
    assign cfg_pending = cfg_pending_q;

    // Shadow writes are resolved before the swap so a write in the swap
    // cycle is carried into the active bank. The swap only happens with
    // every stage empty, so in-flight windows never see a config change.
    always_comb begin
        map_sh_d      = map_sh_q;
        coef_sh_d     = coef_sh_q;
        map_act_d     = map_act_q;
        coef_act_d    = coef_act_q;
        cfg_pending_d = cfg_pending_q || cfg_commit;
        if (cfg_we) begin
            if (!cfg_sel && ({1'b0, cfg_addr} < (ADDR_W + 1)'(NPIX))) begin
                map_sh_d[cfg_addr] = cfg_data[GIDX_W-1:0];
            end else if (cfg_sel && ({1'b0, cfg_addr} < (ADDR_W + 1)'(NGROUP))) begin
                coef_sh_d[cfg_addr[GIDX_W-1:0]] = cfg_data;
            end
        end
        if (swap) begin
            map_act_d     = map_sh_d;
            coef_act_d    = coef_sh_d;
            cfg_pending_d = 1'b0;
        end
    end

    // Stage 1: group sums. Map values at or above NGROUP match no group.
    always_comb begin
        for (int g = 0; g < NGROUP; g++) begin
            sum_calc[g] = '0;
            for (int p = 0; p < NPIX; p++) begin
                if (map_act_q[p] == GIDX_W'(g)) begin
                    sum_calc[g] = sum_calc[g]
                                + {{(SUM_W - PIX_W){pix_q[p][PIX_W-1]}}, pix_q[p]};
                end
            end
        end
    end

    // Stages 2 and 3: full-width products, then sign-extended accumulate.
    always_comb begin
        acc_calc = '0;
        for (int g = 0; g < NGROUP; g++) begin
            prod_calc[g] = $signed({{(PROD_W - SUM_W){sum_q[g][SUM_W-1]}}, sum_q[g]})
                         * $signed({{(PROD_W - COEFF_W){coef_act_q[g][COEFF_W-1]}}, coef_act_q[g]});
            acc_calc     = acc_calc + {{(ACC_W - PROD_W){prod_q[g][PROD_W-1]}}, prod_q[g]};
        end
    end

    // Stage 4: add one half LSB and floor-shift (round half-up), then clip.
    always_comb begin
        rnd      = acc_q + HALF;
        shifted  = rnd >>> COEFF_FRAC;
        out_calc = shifted[OUT_W-1:0];
        sat_calc = 1'b0;
        if (shifted > OUT_MAX) begin
            out_calc = OUT_MAX[OUT_W-1:0];
            sat_calc = 1'b1;
        end else if (shifted < OUT_MIN) begin
            out_calc = OUT_MIN[OUT_W-1:0];
            sat_calc = 1'b1;
        end
    end

    // The whole pipeline moves together on adv. The output register holds
    // while the consumer stalls, so no result is dropped or repeated.
    always_comb begin
        valid_d    = valid_q;
        pix_d      = pix_q;
        sum_d      = sum_q;
        prod_d     = prod_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (adv) begin
            valid_d = {valid_q[3:0], accept};
            if (accept) begin
                for (int p = 0; p < NPIX; p++) begin
                    pix_d[p] = in_pixels[p*PIX_W +: PIX_W];
                end
            end
            sum_d      = sum_calc;
            prod_d     = prod_calc;
            acc_d      = acc_calc;
            out_data_d = out_calc;
            out_sat_d  = sat_calc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NPIX; p++) begin
                map_sh_q[p]  <= '0;
                map_act_q[p] <= '0;
                pix_q[p]     <= '0;
            end
            for (int g = 0; g < NGROUP; g++) begin
                coef_sh_q[g]  <= '0;
                coef_act_q[g] <= '0;
                sum_q[g]      <= '0;
                prod_q[g]     <= '0;
            end
            cfg_pending_q <= 1'b0;
            valid_q       <= '0;
            acc_q         <= '0;
            out_data_q    <= '0;
            out_sat_q     <= 1'b0;
        end else begin
            map_sh_q      <= map_sh_d;
            map_act_q     <= map_act_d;
            coef_sh_q     <= coef_sh_d;
            coef_act_q    <= coef_act_d;
            cfg_pending_q <= cfg_pending_d;
            valid_q       <= valid_d;
            pix_q         <= pix_d;
            sum_q         <= sum_d;
            prod_q        <= prod_d;
            acc_q         <= acc_d;
            out_data_q    <= out_data_d;
            out_sat_q     <= out_sat_d;
        end
    end

endmodule
